pipelined_add_sub: RTL

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit

---
 rtl/pipelined_add_sub.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake for a, b, cin, sub
//   a, b                  WIDTH-bit operands
//   cin                   carry-in (add mode only)
//   sub                   0: a+b+cin, 1: a-b
//   out_valid/out_ready   downstream handshake for sum, cout, ovf
//   sum, cout, ovf        registered result, carry-out, signed overflow
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned SW1  = SW + 1;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES == 0 || WIDTH == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a nonzero multiple of STAGES");
  end

  // Per-stage state: valid, carry out of the slice just processed, full-width
  // operand skew (a and inverted b), and the partially built sum.
  logic [STAGES-1:0]            v_q,  v_d;
  logic [STAGES-1:0]            c_q,  c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q,  a_d;
  logic [STAGES-1:0][WIDTH-1:0] bx_q, bx_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q,  s_d;
  logic                         ovf_q, ovf_d;

  // Stage inputs: index 0 is the upstream port, index k>0 is stage k-1.
  logic [STAGES:0]              v_p;
  logic [STAGES:0]              c_p;
  logic [STAGES:0][WIDTH-1:0]   a_p;
  logic [STAGES:0][WIDTH-1:0]   bx_p;
  logic [STAGES:0][WIDTH-1:0]   s_p;

  logic stall_c;
  logic accept_c;

  // Global stall: a result waiting on the output freezes the whole pipe.
  assign stall_c  = v_q[LAST] & ~out_ready;
  assign in_ready = rst_n & ~stall_c;
  assign accept_c = in_valid & in_ready;

  // Next-state for every slice; bubbles advance the valid bit but keep data.
  always_comb begin
    logic [SW:0] slice;
    slice = '0;
    v_p   = {v_q, accept_c};
    c_p   = {c_q, sub | cin};
    a_p   = {a_q, a};
    bx_p  = {bx_q, b ^ {WIDTH{sub}}};
    s_p   = {s_q, WIDTH'(0)};

    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    bx_d  = bx_q;
    s_d   = s_q;
    ovf_d = ovf_q;

    if (!stall_c) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        v_d[k] = v_p[k];
        if (v_p[k]) begin
          slice = {1'b0, a_p[k][k*SW +: SW]} + {1'b0, bx_p[k][k*SW +: SW]}
                + SW1'(c_p[k]);
          a_d[k]  = a_p[k];
          bx_d[k] = bx_p[k];
          s_d[k]  = s_p[k];
          s_d[k][k*SW +: SW] = slice[SW-1:0];
          c_d[k]  = slice[SW];
        end
      end
      // Overflow is resolved alongside the top slice so it leaves with the sum.
      if (v_p[LAST]) begin
        ovf_d = (a_p[LAST][WIDTH-1] == bx_p[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      bx_q  <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      bx_q  <= bx_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule
